// File: rtl/clock_divmux.sv
`timescale 1ns/1ps
// clock_divmux: CPU clock generator dividing the single PLL clock by one of four
// switch-selected ratios, with a synchronised/debounced selector and a clean hold-low.
module clock_divmux #(
  parameter int unsigned DIV_W     = 20,
  parameter int unsigned DIV0      = 1000000,
  parameter int unsigned DIV1      = 125,
  parameter int unsigned DIV2      = 8000,
  parameter int unsigned DIV3      = 10,
  parameter logic [1:0]  RESET_SEL = 2'b11,
  parameter int unsigned DEB_W     = 18,
  parameter int unsigned DEBOUNCE  = 250000
) (
  input  logic       pll0_250MHz,
  input  logic       reset,
  input  logic [1:0] sw,
  input  logic       hold,
  output logic       cpuclk,
  output logic       cpuclk_rise,
  output logic [1:0] sel_active,
  output logic       switch_pending,
  output logic       stopped
);

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_div;
  logic [DIV_W-1:0] w_last;
  logic [DIV_W-1:0] w_half;
  logic [DIV_W-1:0] w_cnt_inc;
  logic             r_cpuclk;
  logic             r_rise;
  logic             r_stopped;
  logic [1:0]       r_sel_active;
  logic [1:0]       r_sel_req;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [DEB_W-1:0] w_deb_next;
  logic             w_wrap;
  logic             w_sync_chg;
  logic             w_accept;

  always_comb begin
    case (r_sel_active)
      2'b00:   w_div = DIV_W'(DIV0);
      2'b01:   w_div = DIV_W'(DIV1);
      2'b10:   w_div = DIV_W'(DIV2);
      default: w_div = DIV_W'(DIV3);
    endcase
  end

  assign w_last    = w_div - DIV_W'(1);
  assign w_half    = w_div >> 1;
  assign w_cnt_inc = r_cnt + DIV_W'(1);
  assign w_wrap    = (r_cnt == w_last);

  // At the wrap the clock is already low; hold parks the counter there, so the
  // high phase always completes and the rise follows the first cycle without hold.
  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_cpuclk     <= 1'b0;
      r_rise       <= 1'b0;
      r_stopped    <= 1'b0;
      r_sel_active <= RESET_SEL;
    end else if (w_wrap) begin
      r_cpuclk  <= ~hold;
      r_rise    <= ~hold;
      r_stopped <= hold;
      if (!hold) begin
        r_cnt        <= '0;
        r_sel_active <= r_sel_req;
      end
    end else begin
      r_cnt  <= w_cnt_inc;
      r_rise <= 1'b0;
      if (w_cnt_inc == w_half) begin
        r_cpuclk <= 1'b0;
      end
    end
  end

  // r_sync1 != r_sync2 means the synchronised value changes on this edge.
  assign w_sync_chg = (r_sync1 != r_sync2);

  always_comb begin
    w_deb_next = r_deb_cnt;
    if (w_sync_chg) begin
      w_deb_next = '0;
    end else if (r_deb_cnt != DEB_MAX) begin
      w_deb_next = r_deb_cnt + DEB_W'(1);
    end
  end

  assign w_accept = !w_sync_chg && (w_deb_next == DEB_MAX) && (r_sync2 != r_sel_req);

  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      r_sync1   <= RESET_SEL;
      r_sync2   <= RESET_SEL;
      r_deb_cnt <= '0;
      r_sel_req <= RESET_SEL;
    end else begin
      r_sync1   <= sw;
      r_sync2   <= r_sync1;
      r_deb_cnt <= w_deb_next;
      if (w_accept) begin
        r_sel_req <= r_sync2;
      end
    end
  end

  assign cpuclk         = r_cpuclk;
  assign cpuclk_rise    = r_rise;
  assign sel_active     = r_sel_active;
  assign stopped        = r_stopped;
  assign switch_pending = (r_sel_req != r_sel_active);

endmodule

// File: tb/tb_clock_divmux.sv
`timescale 1ns/1ps
// tb_clock_divmux: cycle scoreboard against a behavioural model of the divider and
// switch path, plus directed checks of timing boundaries (first rise, debounce, hold).
module tb_clock_divmux;

  localparam int DEB = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sw    = 2'b11;
  logic       hold  = 1'b0;
  logic       cpuclk;
  logic       cpuclk_rise;
  logic [1:0] sel_active;
  logic       switch_pending;
  logic       stopped;

  int n_tests = 0;
  int n_fail  = 0;

  clock_divmux #(
    .DIV_W(20), .DIV0(8), .DIV1(5), .DIV2(4), .DIV3(2),
    .RESET_SEL(2'b11), .DEB_W(18), .DEBOUNCE(DEB)
  ) dut (
    .pll0_250MHz(clk), .reset(reset), .sw(sw), .hold(hold),
    .cpuclk(cpuclk), .cpuclk_rise(cpuclk_rise), .sel_active(sel_active),
    .switch_pending(switch_pending), .stopped(stopped)
  );

  always #2 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model, stepped on every active edge; expectations go to the scoreboard.
  int         m_cnt, m_stable;
  logic       m_clk, m_rise, m_stop;
  logic [1:0] m_sel, m_req, m_s1, m_s2;
  logic [5:0] sb[$];

  function automatic int div_of(input logic [1:0] s);
    case (s)
      2'b00:   return 8;
      2'b01:   return 5;
      2'b10:   return 4;
      default: return 2;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_stable = 0; m_clk = 0; m_rise = 0; m_stop = 0;
    m_sel = 2'b11; m_req = 2'b11; m_s1 = 2'b11; m_s2 = 2'b11;
  endtask

  task automatic model_step();
    int d;
    d = div_of(m_sel);
    if (m_cnt == d - 1) begin
      if (!hold) begin
        m_cnt = 0; m_clk = 1; m_rise = 1; m_stop = 0; m_sel = m_req;
      end else begin
        m_clk = 0; m_rise = 0; m_stop = 1;
      end
    end else begin
      m_cnt++;
      if (m_cnt == d / 2) m_clk = 0;
      m_rise = 0;
    end
    if (m_s1 != m_s2) m_stable = 0;
    else if (m_stable < DEB) m_stable++;
    if (m_stable == DEB && m_s2 != m_req) m_req = m_s2;
    m_s2 = m_s1;
    m_s1 = sw;
    sb.push_back({m_clk, m_rise, m_sel, (m_req != m_sel), m_stop});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_reset();
        sb.delete();
      end else begin
        model_step();
      end
    end
  end

  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (!reset && sb.size() > 0) begin
        e = sb.pop_front();
        check_val("cycle", 32'({cpuclk, cpuclk_rise, sel_active, switch_pending, stopped}), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset(input string t);
    check_val({t, "_cpuclk"}, 32'(cpuclk), 0);
    check_val({t, "_rise"}, 32'(cpuclk_rise), 0);
    check_val({t, "_sel"}, 32'(sel_active), 3);
    check_val({t, "_pending"}, 32'(switch_pending), 0);
    check_val({t, "_stopped"}, 32'(stopped), 0);
  endtask

  task automatic wait_rise();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cpuclk_rise && k < 100);
    if (!cpuclk_rise) check_val("rise_timeout", 32'(cpuclk_rise), 1);
  endtask

  task automatic wait_pending();
    int k;
    k = 0;
    while (!switch_pending && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!switch_pending) check_val("pending_timeout", 32'(switch_pending), 1);
  endtask

  // Called on a rise sample; returns on the following rise sample.
  task automatic measure(output int hi, output int lo);
    hi = 1;
    lo = 0;
    @(negedge clk);
    while (cpuclk && !cpuclk_rise && hi < 64) begin
      hi++;
      @(negedge clk);
    end
    while (!cpuclk_rise && lo < 64) begin
      lo++;
      @(negedge clk);
    end
    if (!cpuclk_rise) check_val("period_timeout", 32'(cpuclk_rise), 1);
  endtask

  task automatic first_run(input string t);
    int k, hi, lo;
    reset = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cpuclk_rise && k < 20);
    check_val({t, "_first_rise_edge"}, k, 2);
    check_val({t, "_first_cpuclk"}, 32'(cpuclk), 1);
    check_val({t, "_sel"}, 32'(sel_active), 3);
    for (int i = 0; i < 2; i++) begin
      measure(hi, lo);
      check_val({t, "_hi"}, hi, 1);
      check_val({t, "_lo"}, lo, 1);
    end
  endtask

  initial begin
    int hi, lo, first, saw, nhi, first_stop;

    repeat (3) @(negedge clk);
    check_reset("rst0");
    first_run("start");

    // Switch 11 -> 01: accepted 2 sync + 4 debounce edges after the change.
    sw = 2'b01;
    first = 0;
    for (int i = 1; i <= 10 && first == 0; i++) begin
      @(negedge clk);
      if (switch_pending) first = i;
    end
    check_val("sw_accept_delay", first, 6);
    wait_rise();
    check_val("sw01_sel", 32'(sel_active), 1);
    check_val("sw01_pending_clear", 32'(switch_pending), 0);
    for (int i = 0; i < 2; i++) begin
      measure(hi, lo);
      check_val("sw01_hi", hi, 2);
      check_val("sw01_lo", lo, 3);
    end

    // Switch bounce faster than the debounce window is never accepted.
    saw = 0;
    for (int i = 0; i < 36; i++) begin
      if (i % 3 == 0) sw = (i % 6 == 0) ? 2'b00 : 2'b01;
      @(negedge clk);
      if (switch_pending) saw = 1;
    end
    check_val("bounce_no_accept", saw, 0);
    wait_rise();
    check_val("bounce_sel", 32'(sel_active), 1);
    measure(hi, lo);
    check_val("bounce_hi", hi, 2);
    check_val("bounce_lo", lo, 3);

    // D=8 with hold raised at cnt=2.
    sw = 2'b00;
    wait_pending();
    wait_rise();
    check_val("sw00_sel", 32'(sel_active), 0);
    nhi = 0;
    first_stop = -1;
    for (int idx = 0; idx <= 12; idx++) begin
      if (idx > 0) @(negedge clk);
      if (idx == 2) hold = 1'b1;
      if (cpuclk) nhi++;
      if (stopped && first_stop < 0) first_stop = idx;
    end
    check_val("hold_high_cycles", nhi, 4);
    check_val("hold_stop_idx", first_stop, 8);
    check_val("hold_parked_low", 32'(cpuclk), 0);
    hold = 1'b0;
    @(negedge clk);
    check_val("release_rise", 32'(cpuclk_rise), 1);
    check_val("release_cpuclk", 32'(cpuclk), 1);
    check_val("release_stopped", 32'(stopped), 0);

    // Request 00 -> 11 during the high phase: current period stays 4/4.
    sw = 2'b11;
    measure(hi, lo);
    check_val("midsw_hi", hi, 4);
    check_val("midsw_lo", lo, 4);
    check_val("midsw_sel", 32'(sel_active), 3);
    measure(hi, lo);
    check_val("midsw_next_hi", hi, 1);
    check_val("midsw_next_lo", lo, 1);

    // Async reset mid-period with D=5.
    sw = 2'b01;
    wait_pending();
    wait_rise();
    check_val("pre_reset_sel", 32'(sel_active), 1);
    @(negedge clk);
    check_val("pre_reset_high", 32'(cpuclk), 1);
    #1 reset = 1'b1;
    #0.5;
    check_reset("async_rst");
    sw = 2'b11;
    repeat (3) @(negedge clk);
    check_reset("rst1");
    first_run("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
